// File: rtl/jk_bank_driver_if.sv
// Target-word handshake between the register-bank client and jk_bank_driver.
interface jk_bank_driver_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;

  // Client side: offers target words.
  modport master (
    output tgt_valid,
    output tgt_data,
    input  tgt_ready
  );

  // Driver side: accepts target words.
  modport slave (
    input  tgt_valid,
    input  tgt_data,
    output tgt_ready
  );
endinterface

// File: rtl/jk_bank_driver.sv
// Excitation controller: writes a target word into a bank of JK flip-flops,
// verifies it through the (optionally delayed) q readback and re-drives on
// mismatch up to MAX_RETRY times before flagging a sticky error.
module jk_bank_driver #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned FB_LAT      = 0,
  parameter int unsigned MAX_RETRY   = 2,
  parameter int unsigned TOGGLE_PREF = 0
) (
  input  logic               clk,
  input  logic               clr,
  jk_bank_driver_if.slave    tgt,
  input  logic [WIDTH-1:0]   q_fb,
  output logic [WIDTH-1:0]   j,
  output logic [WIDTH-1:0]   k,
  output logic               ff_clr_n,
  output logic               done,
  output logic               err,
  output logic [1:0]         retries
);

  localparam int unsigned CNT_W  = $clog2(MAX_RETRY + 2);
  localparam int unsigned WCNT_W = $clog2(FB_LAT + 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_WAIT  = 2'd2,
    S_CHECK = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   tgt_q, tgt_q_nxt;
  logic [WIDTH-1:0]   j_nxt, k_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [WCNT_W-1:0]  wcnt, wcnt_nxt;
  logic               done_nxt, err_nxt, ready_nxt;
  logic [1:0]         retries_nxt, ret_sat;
  logic [WIDTH-1:0]   exc_t, diff, exc_j, exc_k;

  // The word being excited: fresh input on acceptance, latched target on retry.
  assign exc_t   = (state == S_IDLE) ? tgt.tgt_data : tgt_q;
  assign ret_sat = (32'(cnt) > 32'd3) ? 2'd3 : 2'(cnt);

  // Per-bit J/K excitation of exc_t against the current readback.
  always_comb begin
    diff = exc_t ^ q_fb;
    if (TOGGLE_PREF != 0) begin
      exc_j = diff;
      exc_k = diff;
    end else begin
      exc_j = diff & exc_t;
      exc_k = diff & ~exc_t;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt   = state;
    tgt_q_nxt   = tgt_q;
    j_nxt       = '0;
    k_nxt       = '0;
    cnt_nxt     = cnt;
    wcnt_nxt    = wcnt;
    done_nxt    = 1'b0;
    err_nxt     = err;
    retries_nxt = retries;
    case (state)
      S_IDLE: begin
        if (tgt.tgt_valid && tgt.tgt_ready) begin
          tgt_q_nxt = tgt.tgt_data;
          cnt_nxt   = '0;
          j_nxt     = exc_j;
          k_nxt     = exc_k;
          state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (FB_LAT > 0) begin
          wcnt_nxt  = WCNT_W'(FB_LAT);
          state_nxt = S_WAIT;
        end else begin
          state_nxt = S_CHECK;
        end
      end
      S_WAIT: begin
        wcnt_nxt = wcnt - WCNT_W'(1);
        if (wcnt <= WCNT_W'(1)) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (q_fb == tgt_q) begin
          done_nxt    = 1'b1;
          retries_nxt = ret_sat;
          state_nxt   = S_IDLE;
        end else if (cnt < CNT_W'(MAX_RETRY)) begin
          cnt_nxt   = cnt + CNT_W'(1);
          j_nxt     = exc_j;
          k_nxt     = exc_k;
          state_nxt = S_DRIVE;
        end else begin
          err_nxt     = 1'b1;
          done_nxt    = 1'b1;
          retries_nxt = ret_sat;
          state_nxt   = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    ready_nxt = (state_nxt == S_IDLE);
  end

  // State and registered outputs; clr also holds the bank in clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state         <= S_IDLE;
      tgt_q         <= '0;
      cnt           <= '0;
      wcnt          <= '0;
      j             <= '0;
      k             <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      retries       <= 2'd0;
      tgt.tgt_ready <= 1'b0;
      ff_clr_n      <= 1'b0;
    end else begin
      state         <= state_nxt;
      tgt_q         <= tgt_q_nxt;
      cnt           <= cnt_nxt;
      wcnt          <= wcnt_nxt;
      j             <= j_nxt;
      k             <= k_nxt;
      done          <= done_nxt;
      err           <= err_nxt;
      retries       <= retries_nxt;
      tgt.tgt_ready <= ready_nxt;
      ff_clr_n      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: three lanes (set/reset, toggle, FB_LAT=2) each
// driving its own modelled JK bank, with an injectable stuck-at-0 readback.
module tb_jk_bank_driver;

  localparam int MAXR = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr;
  logic [2:0] tv;
  logic [3:0] td    [3];
  logic [3:0] stuck [3];
  logic [2:0] tr, dn, er, ffc;
  logic [3:0] jw [3];
  logic [3:0] kw [3];
  logic [3:0] bq [3];
  logic [1:0] rt [3];

  int cyc = 0;
  int n_tests, n_fail;
  logic [3:0] exp_bank [3];
  bit   [2:0] exp_err;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_lane
    jk_bank_driver_if #(.WIDTH(4)) tif ();
    logic [3:0] bank = 4'd0;
    logic [3:0] d1 = 4'd0;
    logic [3:0] d2 = 4'd0;
    logic [3:0] qd;

    assign tif.tgt_valid = tv[g];
    assign tif.tgt_data  = td[g];
    assign tr[g]         = tif.tgt_ready;

    jk_bank_driver #(
      .WIDTH(4), .FB_LAT((g == 2) ? 2 : 0), .MAX_RETRY(MAXR),
      .TOGGLE_PREF((g == 1) ? 1 : 0)
    ) u_dut (
      .clk(clk), .clr(clr), .tgt(tif), .q_fb(qd & ~stuck[g]),
      .j(jw[g]), .k(kw[g]), .ff_clr_n(ffc[g]), .done(dn[g]),
      .err(er[g]), .retries(rt[g])
    );

    // Bank of jk_ff cells with clear, plus the readback delay line.
    always @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
        if (!ffc[g]) bank[b] <= 1'b0;
        else begin
          case ({jw[g][b], kw[g][b]})
            2'b01:   bank[b] <= 1'b0;
            2'b10:   bank[b] <= 1'b1;
            2'b11:   bank[b] <= ~bank[b];
            default: bank[b] <= bank[b];
          endcase
        end
      end
      d1 <= bank;
      d2 <= d1;
    end
    assign qd    = (g == 2) ? d2 : bank;
    assign bq[g] = bank;
  end

  // Expected outcome of writing t on lane ln: changing bits go to t (or flip
  // when toggling); a write passes once the visible readback equals t.
  function automatic void model(input int ln, input logic [3:0] t,
                                output logic [3:0] ej, output logic [3:0] ek,
                                output int elat, output int eret, output bit eerr);
    int L = (ln == 2) ? 2 : 0;
    bit tp = (ln == 1);
    logic [3:0] b, s, d;
    b = exp_bank[ln];
    s = stuck[ln];
    d = (b & ~s) ^ t;
    ej = tp ? d : (d & t);
    ek = tp ? d : (d & ~t);
    eret = MAXR;
    eerr = 1'b1;
    for (int a = 0; a <= MAXR; a++) begin
      d = (b & ~s) ^ t;
      b = tp ? (b ^ d) : ((b & ~d) | (t & d));
      if ((b & ~s) == t) begin
        eret = a;
        eerr = 1'b0;
        break;
      end
    end
    elat = 3 + L + eret * (2 + L);
    exp_bank[ln] = b;
    exp_err[ln]  = exp_err[ln] | eerr;
  endfunction

  // One write on a lane; reports what was observed, compares nothing.
  task automatic do_write(input int ln, input logic [3:0] t, output int lat,
                          output logic [3:0] fj, output logic [3:0] fk,
                          output int nd, output bit busy_ok, output bit to);
    int acc, w;
    lat = 0; fj = '0; fk = '0; nd = 0; busy_ok = 1'b1; to = 1'b0;
    @(negedge clk);
    tv[ln] = 1'b1;
    td[ln] = t;
    w = 0;
    while (!tr[ln] && w < 10) begin @(negedge clk); w++; end
    if (!tr[ln]) begin to = 1'b1; tv[ln] = 1'b0; return; end
    acc = cyc;
    @(negedge clk);
    tv[ln] = 1'b0;
    td[ln] = 4'($urandom);
    fj = jw[ln];
    fk = kw[ln];
    w = 0;
    while (!dn[ln] && w < 40) begin
      if ((jw[ln] | kw[ln]) != 4'd0) nd++;
      if (tr[ln]) busy_ok = 1'b0;
      @(negedge clk);
      w++;
    end
    if (!dn[ln]) to = 1'b1;
    else lat = cyc - acc;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if ({ffc, tr, dn} !== 9'd0) begin
        n_fail++;
        $display("FAIL reset_hold ffc/ready/done: got %b, expected 000000000", {ffc, tr, dn});
      end
    end
    clr = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ffc !== 3'b111) begin n_fail++; $display("FAIL reset_release ff_clr_n: got %b, expected 111", ffc); end
    n_tests++;
    if (tr !== 3'b111) begin n_fail++; $display("FAIL reset_release ready: got %b, expected 111", tr); end
    n_tests++;
    if ({jw[0], kw[0], jw[1], kw[1], jw[2], kw[2]} !== 24'd0) begin
      n_fail++; $display("FAIL reset_release jk: got nonzero, expected 0");
    end
    n_tests++;
    if ({er, rt[0], rt[1], rt[2]} !== 9'd0) begin
      n_fail++; $display("FAIL reset_release err/retries: got %h, expected 0", {er, rt[0], rt[1], rt[2]});
    end
    n_tests++;
    if ({bq[0], bq[1], bq[2]} !== 12'd0) begin
      n_fail++; $display("FAIL reset_release bank: got %h, expected 000", {bq[0], bq[1], bq[2]});
    end
  endtask

  task automatic test_set_reset();
    logic [3:0] ej, ek, fj, fk;
    int elat, eret, lat, nd;
    bit eerr, bok, to;
    model(0, 4'b1010, ej, ek, elat, eret, eerr);
    do_write(0, 4'b1010, lat, fj, fk, nd, bok, to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL set_reset timeout: got 1, expected 0"); end
    n_tests++;
    if ({fj, fk} !== {ej, ek}) begin n_fail++; $display("FAIL set_reset jk: got %h, expected %h", {fj, fk}, {ej, ek}); end
    n_tests++;
    if (lat !== elat) begin n_fail++; $display("FAIL set_reset latency: got %0d, expected %0d", lat, elat); end
    n_tests++;
    if ({rt[0], er[0], tr[0]} !== {2'(eret), exp_err[0], 1'b1}) begin
      n_fail++; $display("FAIL set_reset retries/err/ready: got %b, expected %b", {rt[0], er[0], tr[0]}, {2'(eret), exp_err[0], 1'b1});
    end
    n_tests++;
    if (bq[0] !== exp_bank[0]) begin n_fail++; $display("FAIL set_reset bank: got %b, expected %b", bq[0], exp_bank[0]); end
    n_tests++;
    if (!bok) begin n_fail++; $display("FAIL set_reset ready_busy: got 1, expected 0"); end
    @(negedge clk);
    n_tests++;
    if (dn[0] !== 1'b0) begin n_fail++; $display("FAIL set_reset done_pulse: got 1, expected 0"); end
  endtask

  task automatic test_toggle();
    logic [3:0] ej, ek, fj, fk;
    int elat, eret, lat, nd;
    bit eerr, bok, to;
    model(1, 4'b1010, ej, ek, elat, eret, eerr);
    do_write(1, 4'b1010, lat, fj, fk, nd, bok, to);
    model(1, 4'b0110, ej, ek, elat, eret, eerr);
    do_write(1, 4'b0110, lat, fj, fk, nd, bok, to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL toggle timeout: got 1, expected 0"); end
    n_tests++;
    if ({fj, fk} !== {ej, ek}) begin n_fail++; $display("FAIL toggle jk: got %h, expected %h", {fj, fk}, {ej, ek}); end
    n_tests++;
    if (lat !== elat) begin n_fail++; $display("FAIL toggle latency: got %0d, expected %0d", lat, elat); end
    n_tests++;
    if (bq[1] !== exp_bank[1]) begin n_fail++; $display("FAIL toggle bank: got %b, expected %b", bq[1], exp_bank[1]); end
  endtask

  task automatic test_retry();
    logic [3:0] ej, ek, fj, fk;
    int elat, eret, lat, nd;
    bit eerr, bok, to;
    stuck[0] = 4'b0001;
    model(0, 4'b0001, ej, ek, elat, eret, eerr);
    do_write(0, 4'b0001, lat, fj, fk, nd, bok, to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL retry timeout: got 1, expected 0"); end
    n_tests++;
    if (lat !== elat) begin n_fail++; $display("FAIL retry latency: got %0d, expected %0d", lat, elat); end
    n_tests++;
    if (nd !== eret + 1) begin n_fail++; $display("FAIL retry drive_count: got %0d, expected %0d", nd, eret + 1); end
    n_tests++;
    if ({rt[0], er[0]} !== {2'(eret), exp_err[0]}) begin
      n_fail++; $display("FAIL retry retries/err: got %b, expected %b", {rt[0], er[0]}, {2'(eret), exp_err[0]});
    end
    stuck[0] = 4'b0000;
    model(0, 4'b0000, ej, ek, elat, eret, eerr);
    do_write(0, 4'b0000, lat, fj, fk, nd, bok, to);
    n_tests++;
    if (lat !== elat) begin n_fail++; $display("FAIL retry_after latency: got %0d, expected %0d", lat, elat); end
    n_tests++;
    if ({rt[0], er[0]} !== {2'(eret), exp_err[0]}) begin
      n_fail++; $display("FAIL retry_after sticky err: got %b, expected %b", {rt[0], er[0]}, {2'(eret), exp_err[0]});
    end
    n_tests++;
    if (bq[0] !== exp_bank[0]) begin n_fail++; $display("FAIL retry_after bank: got %b, expected %b", bq[0], exp_bank[0]); end
  endtask

  task automatic test_fb_lat();
    logic [3:0] ej, ek, fj, fk;
    int elat, eret, lat, nd;
    bit eerr, bok, to;
    model(2, 4'b1111, ej, ek, elat, eret, eerr);
    do_write(2, 4'b1111, lat, fj, fk, nd, bok, to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL fb_lat timeout: got 1, expected 0"); end
    n_tests++;
    if (lat !== elat) begin n_fail++; $display("FAIL fb_lat latency: got %0d, expected %0d", lat, elat); end
    n_tests++;
    if (nd !== 1) begin n_fail++; $display("FAIL fb_lat drive_cycles: got %0d, expected 1", nd); end
    n_tests++;
    if ({fj, fk} !== {ej, ek}) begin n_fail++; $display("FAIL fb_lat jk: got %h, expected %h", {fj, fk}, {ej, ek}); end
    n_tests++;
    if (bq[2] !== exp_bank[2]) begin n_fail++; $display("FAIL fb_lat bank: got %b, expected %b", bq[2], exp_bank[2]); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] a, b, ej, ek, ebank_a, bank_a, fj, fk;
    int elat_a, elat_b, eret, acc_a, acc_b, done_a, done_b, w;
    bit eerr, tr_a;
    a = 4'($urandom);
    b = 4'($urandom);
    model(2, a, ej, ek, elat_a, eret, eerr);
    ebank_a = exp_bank[2];
    model(2, b, ej, ek, elat_b, eret, eerr);
    @(negedge clk);
    tv[2] = 1'b1;
    td[2] = a;
    w = 0;
    while (!tr[2] && w < 10) begin @(negedge clk); w++; end
    acc_a = cyc;
    @(negedge clk);
    td[2] = b;
    w = 0;
    while (!dn[2] && w < 40) begin @(negedge clk); w++; end
    done_a = cyc;
    tr_a   = tr[2];
    bank_a = bq[2];
    acc_b  = cyc;
    @(negedge clk);
    tv[2] = 1'b0;
    fj = jw[2];
    fk = kw[2];
    w = 0;
    while (!dn[2] && w < 40) begin @(negedge clk); w++; end
    done_b = cyc;
    n_tests++;
    if (done_a - acc_a !== elat_a) begin n_fail++; $display("FAIL b2b latency_a: got %0d, expected %0d", done_a - acc_a, elat_a); end
    n_tests++;
    if (tr_a !== 1'b1) begin n_fail++; $display("FAIL b2b ready_in_done: got %b, expected 1", tr_a); end
    n_tests++;
    if (bank_a !== ebank_a) begin n_fail++; $display("FAIL b2b bank_a: got %b, expected %b", bank_a, ebank_a); end
    n_tests++;
    if ({fj, fk} !== {ej, ek}) begin n_fail++; $display("FAIL b2b jk_b: got %h, expected %h", {fj, fk}, {ej, ek}); end
    n_tests++;
    if (done_b - acc_b !== elat_b) begin n_fail++; $display("FAIL b2b latency_b: got %0d, expected %0d", done_b - acc_b, elat_b); end
    n_tests++;
    if (bq[2] !== exp_bank[2]) begin n_fail++; $display("FAIL b2b bank_b: got %b, expected %b", bq[2], exp_bank[2]); end
  endtask

  task automatic test_random();
    logic [3:0] t, ej, ek, fj, fk;
    int ln, elat, eret, lat, nd;
    bit eerr, bok, to;
    for (int i = 0; i < 24; i++) begin
      ln = $urandom_range(0, 2);
      t  = 4'($urandom);
      stuck[ln] = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
      model(ln, t, ej, ek, elat, eret, eerr);
      do_write(ln, t, lat, fj, fk, nd, bok, to);
      n_tests++;
      if (to || !bok) begin n_fail++; $display("FAIL random[%0d] handshake: got to=%b busy_ok=%b, expected 0/1", i, to, bok); end
      n_tests++;
      if ({fj, fk} !== {ej, ek}) begin n_fail++; $display("FAIL random[%0d] jk: got %h, expected %h", i, {fj, fk}, {ej, ek}); end
      n_tests++;
      if (lat !== elat) begin n_fail++; $display("FAIL random[%0d] latency: got %0d, expected %0d", i, lat, elat); end
      n_tests++;
      if ({rt[ln], er[ln]} !== {2'(eret), exp_err[ln]}) begin
        n_fail++; $display("FAIL random[%0d] retries/err: got %b, expected %b", i, {rt[ln], er[ln]}, {2'(eret), exp_err[ln]});
      end
      n_tests++;
      if (bq[ln] !== exp_bank[ln]) begin n_fail++; $display("FAIL random[%0d] bank: got %b, expected %b", i, bq[ln], exp_bank[ln]); end
      stuck[ln] = 4'd0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_clr_mid_drive();
    int w, seen;
    @(negedge clk);
    tv[0] = 1'b1;
    td[0] = 4'b0101;
    w = 0;
    while (!tr[0] && w < 10) begin @(negedge clk); w++; end
    n_tests++;
    if (!tr[0]) begin n_fail++; $display("FAIL clr_mid accept: got ready 0, expected 1"); end
    @(negedge clk);
    tv[0] = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({jw[0], kw[0]} !== 8'd0) begin n_fail++; $display("FAIL clr_mid jk: got %h, expected 00", {jw[0], kw[0]}); end
    n_tests++;
    if ({ffc, dn, tr} !== 9'd0) begin n_fail++; $display("FAIL clr_mid ffc/done/ready: got %b, expected 0", {ffc, dn, tr}); end
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin exp_bank[i] = 4'd0; end
    exp_err = 3'd0;
    @(negedge clk);
    n_tests++;
    if ({ffc, tr} !== 6'b111111) begin n_fail++; $display("FAIL clr_mid release: got %b, expected 111111", {ffc, tr}); end
    n_tests++;
    if (bq[0] !== exp_bank[0]) begin n_fail++; $display("FAIL clr_mid bank: got %b, expected %b", bq[0], exp_bank[0]); end
    n_tests++;
    if ({er, rt[0]} !== {exp_err, 2'd0}) begin n_fail++; $display("FAIL clr_mid err/retries: got %b, expected 0", {er, rt[0]}); end
    seen = 0;
    repeat (4) begin
      if (dn != 3'd0) seen++;
      @(negedge clk);
    end
    n_tests++;
    if (seen !== 0) begin n_fail++; $display("FAIL clr_mid spurious_done: got %0d, expected 0", seen); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clr     = 1'b1;
    tv      = 3'd0;
    exp_err = 3'd0;
    for (int i = 0; i < 3; i++) begin
      td[i] = 4'd0;
      stuck[i] = 4'd0;
      exp_bank[i] = 4'd0;
    end
    test_reset();
    test_set_reset();
    test_toggle();
    test_retry();
    test_fb_lat();
    test_back_to_back();
    test_random();
    test_clr_mid_drive();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_bank_driver.md
# jk_bank_driver

Excitation controller that writes target words into a bank of WIDTH JK flip-flops (`jk_ff` instances: `j`, `k`, `clk`, active-low `clr`, `q`).
- Accepts a target word over a valid/ready handshake.
- Computes per-bit J/K excitation from the bank's current `q`, drives it for exactly one clock, then reads `q` back to confirm the write, re-driving on mismatch up to MAX_RETRY times.
- Sits between the register-bank client logic and the flip-flop bank.
- Owns the bank's clear line.

## Interface
- WIDTH, 4: number of flip-flops in the bank.
- FB_LAT, 0: extra register stages on the `q_fb` path; the block waits this many cycles before comparing.
- MAX_RETRY, 2: re-drive attempts after the first drive, before flagging an error.
- TOGGLE_PREF, 0: 1 encodes changing bits as J=K=1 (toggle); 0 encodes them as J=t, K=~t (set/reset).

Ports:
- clk  in  1  clock; all logic on rising edge.
- clr  in  1  reset; synchronous, active-high.
- tgt_valid  in  1  target word offered.
- tgt_ready  out  1  block can accept a target.
- tgt_data  in  WIDTH  target word.
- q_fb  in  WIDTH  bank `q` outputs, delayed by FB_LAT registers.
- j  out  WIDTH  J inputs to the bank; registered.
- k  out  WIDTH  K inputs to the bank; registered.
- ff_clr_n  out  1  active-low clear to the bank; registered.
- done  out  1  one-cycle pulse when a write completes, pass or fail.
- err  out  1  sticky; a write failed after MAX_RETRY re-drives.
- retries  out  2  re-drives used by the last write; saturates at 3.

## Operation
States:
- IDLE: `tgt_ready`=1; accepts a target.
- DRIVE: J/K are applied to the bank.
- WAIT: present only when FB_LAT>0; lasts FB_LAT cycles.
- CHECK: compares readback against the target.

Excitation per bit, with t = latched target bit and q = `q_fb` bit:
- t==q: J=0, K=0 (hold).
- t!=q with TOGGLE_PREF=1: J=1, K=1.
- t!=q with TOGGLE_PREF=0: J=t, K=~t.

Transitions:
- IDLE -> DRIVE: on `tgt_valid`&&`tgt_ready`. Latch `tgt_data`, clear the retry counter, and register the excitation computed from the current `q_fb`.
- DRIVE -> WAIT when FB_LAT>0, else DRIVE -> CHECK. `j`/`k` return to 0 at this edge.
- WAIT -> CHECK: after FB_LAT cycles.
- CHECK with `q_fb`==target: go to IDLE and pulse `done`.
- CHECK with mismatch and counter<MAX_RETRY: increment the counter, register the excitation from the current `q_fb`, go to DRIVE.
- CHECK with mismatch and counter==MAX_RETRY: set `err`, pulse `done`, go to IDLE.

Output rules:
- `j`/`k` are nonzero only during DRIVE cycles.
- `retries` updates when `done` pulses.
- `tgt_valid` and `tgt_data` are ignored outside IDLE. `tgt_data` is not required to stay stable after acceptance.

Reset behaviour:
- `clr` high at any edge, in any state, including mid-DRIVE: next state IDLE, `j`=`k`=0, `tgt_ready`=0, `done`=0, `err`=0, `retries`=0, `ff_clr_n`=0.
- While `clr` stays high, `ff_clr_n` stays 0, so the bank clears on the same edges.
- First edge with `clr` low: `ff_clr_n` becomes 1 and `tgt_ready` becomes 1.

## Timing
- Acceptance edge is the end of cycle N.
- Cycle N+1 is DRIVE: `j`/`k` are valid, and the bank captures at the end of N+1.
- Cycles N+2 .. N+1+FB_LAT are WAIT.
- Cycle N+2+FB_LAT is CHECK.
- Clean write: `done` and `tgt_ready` are both high in cycle N+3+FB_LAT. Latency is 3+FB_LAT cycles; throughput is one write per 3+FB_LAT cycles.
- Each retry adds 2+FB_LAT cycles.
- `tgt_ready` is low from the cycle after acceptance until the `done` cycle.
- A new target may be accepted in the `done` cycle.
- Target equal to current `q`: still passes through DRIVE, with all-zero J/K, and completes in the normal latency.
- `err` is not cleared by later successful writes; only `clr` clears it.

## Test plan
- Reset release: hold `clr`=1 for 3 cycles, then drop it -> `ff_clr_n`=0 throughout reset and 1 one edge after release; `tgt_ready`=1 one edge after release; `j`=`k`=0; bank `q`=0000.
- WIDTH=4, FB_LAT=0, TOGGLE_PREF=0, bank at 0000, write 1010 -> DRIVE cycle shows `j`=1010, `k`=0000; `done` 3 cycles after acceptance; `retries`=0; `err`=0; bank=1010.
- TOGGLE_PREF=1, bank at 1010, write 0110 -> `j`=`k`=1100 for one cycle; bank=0110; `done` 3 cycles after acceptance.
- Model forces `q_fb` bit0 stuck at 0, MAX_RETRY=2, write 0001 -> three DRIVE cycles; `done` at cycle N+7; `err`=1; `retries`=2; a following write of 0000 passes with `err` still 1.
- FB_LAT=2, write 1111 from 0000 -> `done` at cycle N+5; two back-to-back writes with `tgt_valid` held high are accepted in each `done` cycle.
- Assert `clr` during DRIVE of a write 0101 -> next cycle `j`=`k`=0, `ff_clr_n`=0, no `done`; bank=0000 after release.
